// File: rtl/learn_backtrack.sv
// learn_backtrack
//   Captures the learned literals and the UIP literal from conflict analysis,
//   writes the clause into the next learned-clause slot of the clause table,
//   then pops the assignment trail down to the backtrack level and pulses Done.
//
// Ports:
//   Clk, Reset               clock, asynchronous active-high reset
//   Lit_valid/LID/DecLevel   learned literal strobe from analysis
//   UIP_valid/UIP_LID        UIP literal strobe, ends collection
//   In_ready                 high while literals are accepted (IDLE/COLLECT)
//   CT_wren/addr/slot/LID    clause-table write port (LID 0 = terminator)
//   AIT_popEn                pop request to the trail (combinational)
//   AIT_topDecLevel/empty    trail top decision level and empty flag
//   Done/Overflow            completion pulse, overflow qualifier
//   BT_level/Learned_CID     result of the last completed clause
//   Stat_learned/popped      saturating counters (only with LEARN_STATS_EN)
//
// Optional feature macro: LEARN_STATS_EN
module learn_backtrack #(
    parameter int literals   = 8,
    parameter int clauses    = 16,
    parameter int max_len    = 4,
    parameter int learn_base = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Lit_valid,
    input  logic [$clog2(literals):0]    Lit_LID,
    input  logic [$clog2(literals)-1:0]  Lit_DecLevel,
    input  logic                         UIP_valid,
    input  logic [$clog2(literals):0]    UIP_LID,
    output logic                         In_ready,
    output logic                         CT_wren,
    output logic [$clog2(clauses)-1:0]   CT_addr,
    output logic [$clog2(max_len)-1:0]   CT_slot,
    output logic [$clog2(literals):0]    CT_LID,
    output logic                         AIT_popEn,
    input  logic [$clog2(literals)-1:0]  AIT_topDecLevel,
    input  logic                         AIT_empty,
    output logic                         Done,
    output logic                         Overflow,
    output logic [$clog2(literals)-1:0]  BT_level,
`ifdef LEARN_STATS_EN
    output logic [15:0]                  Stat_learned,
    output logic [15:0]                  Stat_popped,
`endif
    output logic [$clog2(clauses)-1:0]   Learned_CID
);

    localparam int LB = $clog2(literals);
    localparam int CB = $clog2(clauses);
    localparam int SW = $clog2(max_len);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_POP, S_DONE} state_t;

    state_t          state;
    logic [LB:0]     lit_buf [max_len];
    logic [SW-1:0]   count;
    logic [LB-1:0]   max_dl;
    logic            ovf;
    logic [SW-1:0]   wr_idx;
    logic [CB-1:0]   next_cid;

    logic            accepting;
    logic            full;
    logic [SW-1:0]   last_idx;
    logic [LB-1:0]   bt_target;
    logic            pop_cond;

    assign accepting = (state == S_IDLE) || (state == S_COLLECT);
    assign In_ready  = accepting;
    assign full      = (count == SW'(max_len - 1));
    // Terminator slot exists only when the clause does not fill every slot.
    assign last_idx  = full ? count : count + SW'(1);
    assign bt_target = ovf ? '0 : max_dl;
    assign pop_cond  = !AIT_empty && (AIT_topDecLevel > bt_target);
    assign AIT_popEn = (state == S_POP) && pop_cond;

    assign CT_wren = (state == S_WRITE);
    assign CT_addr = CT_wren ? next_cid : '0;
    assign CT_slot = CT_wren ? wr_idx : '0;
    assign CT_LID  = (CT_wren && (wr_idx <= count)) ? lit_buf[wr_idx] : '0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            for (int unsigned i = 0; i < max_len; i++) lit_buf[i] <= '0;
            count       <= '0;
            max_dl      <= '0;
            ovf         <= 1'b0;
            wr_idx      <= '0;
            next_cid    <= CB'(learn_base);
            Done        <= 1'b0;
            Overflow    <= 1'b0;
            BT_level    <= '0;
            Learned_CID <= '0;
`ifdef LEARN_STATS_EN
            Stat_learned <= '0;
            Stat_popped  <= '0;
`endif
        end else begin
`ifdef LEARN_STATS_EN
            if (AIT_popEn && (Stat_popped != 16'hFFFF))
                Stat_popped <= Stat_popped + 16'd1;
`endif
            case (state)
                S_IDLE, S_COLLECT: begin
                    // A same-cycle literal lands before the UIP is taken, so
                    // a literal that overflows here still routes to POP.
                    if (Lit_valid) begin
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            lit_buf[count + SW'(1)] <= Lit_LID;
                            count <= count + SW'(1);
                            if (Lit_DecLevel > max_dl) max_dl <= Lit_DecLevel;
                        end
                    end
                    if (UIP_valid) begin
                        lit_buf[0] <= UIP_LID;
                        wr_idx     <= '0;
                        state      <= (ovf || (Lit_valid && full)) ? S_POP : S_WRITE;
                    end else if (Lit_valid) begin
                        state <= S_COLLECT;
                    end
                end
                S_WRITE: begin
                    if (wr_idx == last_idx) state <= S_POP;
                    else                    wr_idx <= wr_idx + SW'(1);
                end
                S_POP: begin
                    if (!pop_cond) begin
                        Done        <= 1'b1;
                        Overflow    <= ovf;
                        BT_level    <= bt_target;
                        Learned_CID <= next_cid;
                        state       <= S_DONE;
`ifdef LEARN_STATS_EN
                        if (!ovf && (Stat_learned != 16'hFFFF))
                            Stat_learned <= Stat_learned + 16'd1;
`endif
                    end
                end
                S_DONE: begin
                    Done     <= 1'b0;
                    Overflow <= 1'b0;
                    if (!ovf)
                        next_cid <= (next_cid == CB'(clauses - 1)) ? CB'(learn_base)
                                                                   : next_cid + CB'(1);
                    for (int unsigned i = 0; i < max_len; i++) lit_buf[i] <= '0;
                    count  <= '0;
                    max_dl <= '0;
                    ovf    <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_learn_backtrack.sv
// tb_learn_backtrack
//   Scoreboard bench: each issued clause pushes its expected clause-table
//   writes and completion record; a negedge monitor pops and compares.
module tb_learn_backtrack;

    localparam int LITERALS   = 8;
    localparam int CLAUSES    = 16;
    localparam int MAX_LEN    = 4;
    localparam int LEARN_BASE = 8;
    localparam int LB = $clog2(LITERALS);
    localparam int CB = $clog2(CLAUSES);
    localparam int SW = $clog2(MAX_LEN);

    logic          Clk, Reset;
    logic          Lit_valid, UIP_valid;
    logic [LB:0]   Lit_LID, UIP_LID;
    logic [LB-1:0] Lit_DecLevel;
    logic          In_ready, CT_wren, AIT_popEn, AIT_empty, Done, Overflow;
    logic [CB-1:0] CT_addr, Learned_CID;
    logic [SW-1:0] CT_slot;
    logic [LB:0]   CT_LID;
    logic [LB-1:0] AIT_topDecLevel, BT_level;
`ifdef LEARN_STATS_EN
    logic [15:0]   Stat_learned, Stat_popped;
`endif

    learn_backtrack #(
        .literals(LITERALS), .clauses(CLAUSES), .max_len(MAX_LEN), .learn_base(LEARN_BASE)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .Lit_valid(Lit_valid), .Lit_LID(Lit_LID), .Lit_DecLevel(Lit_DecLevel),
        .UIP_valid(UIP_valid), .UIP_LID(UIP_LID), .In_ready(In_ready),
        .CT_wren(CT_wren), .CT_addr(CT_addr), .CT_slot(CT_slot), .CT_LID(CT_LID),
        .AIT_popEn(AIT_popEn), .AIT_topDecLevel(AIT_topDecLevel), .AIT_empty(AIT_empty),
        .Done(Done), .Overflow(Overflow), .BT_level(BT_level),
`ifdef LEARN_STATS_EN
        .Stat_learned(Stat_learned), .Stat_popped(Stat_popped),
`endif
        .Learned_CID(Learned_CID)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct { int addr; int slot; int lid; } wr_t;
    typedef struct { int bt; int cid; int ovf; int pops; } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    tests = 0, fails = 0;
    int    pops_seen = 0, done_count = 0;
    bit    pop_req = 1'b0;
    bit    sb_off = 1'b0;
    int    trail[$];
    int    m_next_cid = LEARN_BASE;
    int    q_lid[$], q_dl[$], q_trail[$];
    wr_t   mw;
    done_t md;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Trail model: pops happen on the clock edge following a sampled pop request.
    always begin
        @(posedge Clk);
        #1;
        if (pop_req && trail.size() > 0) void'(trail.pop_back());
        AIT_empty       = (trail.size() == 0);
        AIT_topDecLevel = (trail.size() == 0) ? '0 : LB'(trail[$]);
    end

    // Monitor / scoreboard
    always @(negedge Clk) begin
        if (Reset) begin
            pops_seen = 0;
            pop_req   = 1'b0;
        end else begin
            pop_req = AIT_popEn;
            if (AIT_popEn) pops_seen++;
            if (CT_wren && !sb_off) begin
                if (exp_wr.size() == 0) begin
                    check("ct_unexpected_write", 1, 0);
                end else begin
                    mw = exp_wr.pop_front();
                    check("ct_addr", int'(CT_addr), mw.addr);
                    check("ct_slot", int'(CT_slot), mw.slot);
                    check("ct_lid", int'(CT_LID), mw.lid);
                end
            end
            if (Done) begin
                done_count++;
                if (!sb_off) begin
                    if (exp_done.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        md = exp_done.pop_front();
                        check("bt_level", int'(BT_level), md.bt);
                        check("learned_cid", int'(Learned_CID), md.cid);
                        check("overflow", int'(Overflow), md.ovf);
                        check("pop_count", pops_seen, md.pops);
                    end
                end
                pops_seen = 0;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: the clause keeps the first max_len-1 literals; an overflowing
    // clause is never written and backtracks to level 0.
    task automatic issue(input int uip, input bit same);
        int n, stored, mx, bt, p, target;
        bit ovf;
        int tmp[$];
        n      = q_lid.size();
        ovf    = (n > MAX_LEN - 1);
        stored = ovf ? MAX_LEN - 1 : n;
        mx = 0;
        for (int i = 0; i < stored; i++) if (q_dl[i] > mx) mx = q_dl[i];
        bt = ovf ? 0 : mx;
        if (!ovf) begin
            exp_wr.push_back('{m_next_cid, 0, uip});
            for (int i = 0; i < stored; i++) exp_wr.push_back('{m_next_cid, i + 1, q_lid[i]});
            if (stored + 1 < MAX_LEN) exp_wr.push_back('{m_next_cid, stored + 1, 0});
        end
        tmp = q_trail;
        p = 0;
        while (tmp.size() > 0 && tmp[$] > bt) begin
            void'(tmp.pop_back());
            p++;
        end
        exp_done.push_back('{bt, m_next_cid, int'(ovf), p});
        if (!ovf) m_next_cid = (m_next_cid == CLAUSES - 1) ? LEARN_BASE : m_next_cid + 1;

        trail = q_trail;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            Lit_valid    = 1'b1;
            Lit_LID      = (LB+1)'(q_lid[i]);
            Lit_DecLevel = LB'(q_dl[i]);
            if (same && i == n - 1) begin
                UIP_valid = 1'b1;
                UIP_LID   = (LB+1)'(uip);
            end
            tick();
            Lit_valid = 1'b0;
            UIP_valid = 1'b0;
            if ($urandom_range(0, 2) == 0 && !(same && i == n - 1)) tick();
        end
        if (!same || n == 0) begin
            UIP_valid = 1'b1;
            UIP_LID   = (LB+1)'(uip);
            tick();
            UIP_valid = 1'b0;
        end
        // Strobes while busy must be ignored.
        target = done_count + 1;
        for (int c = 0; c < 60 && done_count < target; c++) begin
            Lit_valid    = 1'($urandom_range(0, 1));
            Lit_LID      = (LB+1)'($urandom_range(1, 15));
            Lit_DecLevel = LB'($urandom_range(0, 7));
            UIP_valid    = ($urandom_range(0, 3) == 0);
            UIP_LID      = (LB+1)'($urandom_range(1, 15));
            tick();
        end
        Lit_valid    = 1'b0;
        UIP_valid    = 1'b0;
        Lit_DecLevel = '0;
        check("done_seen", done_count, target);
        check("in_ready_after", int'(In_ready), 1);
    endtask

    initial begin
        Reset = 1'b1;
        Lit_valid = 1'b0; UIP_valid = 1'b0;
        Lit_LID = '0; UIP_LID = '0; Lit_DecLevel = '0;
        AIT_empty = 1'b1; AIT_topDecLevel = '0;
        #23;
        check("rst_in_ready", int'(In_ready), 1);
        check("rst_outputs", int'({CT_wren, CT_addr, CT_slot, CT_LID, AIT_popEn,
                                   Done, Overflow, BT_level, Learned_CID}), 0);
        Reset = 1'b0;
        tick();

        // Two literals plus UIP, trail tops 3,3,2
        q_lid = '{5, 9}; q_dl = '{1, 2}; q_trail = '{2, 3, 3};
        issue(3, 1'b0);

        // Asynchronous reset during a clause write
        sb_off = 1'b1;
        trail = '{};
        UIP_valid = 1'b1; UIP_LID = 4'd7;
        tick();
        UIP_valid = 1'b0;
        check("pre_reset_wren", int'(CT_wren), 1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_in_ready", int'(In_ready), 1);
        check("async_rst_outputs", int'({CT_wren, CT_addr, CT_slot, CT_LID, AIT_popEn,
                                         Done, Overflow, BT_level, Learned_CID}), 0);
        tick();
        Reset = 1'b0;
        sb_off = 1'b0;
        m_next_cid = LEARN_BASE;
        tick();

        // Unit clause; then a unit clause whose trail empties first
        q_lid = '{}; q_dl = '{}; q_trail = '{0, 1, 1};
        issue(6, 1'b0);
        q_trail = '{1, 1};
        issue(6, 1'b0);

        // Overflow: four literals with max_len 4
        q_lid = '{2, 4, 6, 8}; q_dl = '{1, 3, 2, 1}; q_trail = '{0, 1, 2};
        issue(10, 1'b0);

        // Literal and UIP in the same cycle after one prior literal
        q_lid = '{11, 12}; q_dl = '{2, 1}; q_trail = '{0, 2, 3};
        issue(13, 1'b1);

        // Successful learns across the CID wrap
        for (int k = 0; k < 9; k++) begin
            int n;
            n = $urandom_range(0, MAX_LEN - 1);
            q_lid = '{}; q_dl = '{}; q_trail = '{};
            for (int i = 0; i < n; i++) begin
                q_lid.push_back($urandom_range(1, 15));
                q_dl.push_back($urandom_range(0, 7));
            end
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) q_trail.push_back($urandom_range(0, 7));
            issue($urandom_range(1, 15), 1'($urandom_range(0, 1)));
        end

        // Random mix including overflow
        for (int k = 0; k < 40; k++) begin
            int n;
            n = $urandom_range(0, MAX_LEN + 1);
            q_lid = '{}; q_dl = '{}; q_trail = '{};
            for (int i = 0; i < n; i++) begin
                q_lid.push_back($urandom_range(1, 15));
                q_dl.push_back($urandom_range(0, 7));
            end
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) q_trail.push_back($urandom_range(0, 7));
            issue($urandom_range(1, 15), 1'($urandom_range(0, 1)));
        end

        tick();
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_dones", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
